alu_shift_sequencer: RTL and testbench

//  Multi-cycle shift controller for the ALU datapath: accepts a word, a shift
//  op and a shift amount, then applies one single-bit step per clock until the

---
 rtl/alu_shift_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_shift_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer
//   Multi-cycle shift controller for the ALU datapath. A start request latches
//   an operand, a shift/rotate op and an amount; the working register then
//   takes one single-bit step per clock until the amount is used up. A
//   start/busy/done handshake connects it to ALU control and the result mux.
//
//   Op codes: 000 SRL, 001 SLL, 010 ROR, 011 ROL. Any other op passes the
//   operand through unchanged, with done one cycle after acceptance.
//
//   Optional feature (compile-time macro ARITH_SHIFT_EN):
//     defined   -> op 100 is SRA (sign bit replicated on each step)
//     undefined -> op 100 is invalid (pass-through)
//
// Ports
//   iClock   in   1      rising-edge clock
//   iReset   in   1      synchronous reset, active-high
//   iStart   in   1      request, sampled only while idle
//   iData    in   WIDTH  operand, latched on an accepted start
//   iOp      in   3      shift/rotate op code
//   iAmount  in   AMT_W  number of single-bit steps
//   oResult  out  WIDTH  working/result register
//   oBusy    out  1      high while not idle
//   oDone    out  1      one-cycle pulse; oResult is final
module alu_shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData,
  input  logic [2:0]       iOp,
  input  logic [AMT_W-1:0] iAmount,
  output logic [WIDTH-1:0] oResult,
  output logic             oBusy,
  output logic             oDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       op;
  logic [AMT_W-1:0] count;

  function automatic logic op_valid(input logic [2:0] o);
    logic v;
    case (o)
      3'b000, 3'b001, 3'b010, 3'b011: v = 1'b1;
`ifdef ARITH_SHIFT_EN
      3'b100:                         v = 1'b1;
`endif
      default:                        v = 1'b0;
    endcase
    return v;
  endfunction

  // One single-bit step of the selected op.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] r,
                                                  input logic [2:0]       o);
    logic [WIDTH-1:0] s;
    case (o)
      3'b000:  s = {1'b0, r[WIDTH-1:1]};
      3'b001:  s = {r[WIDTH-2:0], 1'b0};
      3'b010:  s = {r[0], r[WIDTH-1:1]};
      3'b011:  s = {r[WIDTH-2:0], r[WIDTH-1]};
`ifdef ARITH_SHIFT_EN
      3'b100:  s = {r[WIDTH-1], r[WIDTH-1:1]};
`endif
      default: s = r;
    endcase
    return s;
  endfunction

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    oBusy     = (state != IDLE);
    oDone     = (state == DONE);
    case (state)
      IDLE: begin
        if (iStart) begin
          // Zero amount or an unsupported op skips straight to DONE.
          if ((iAmount != '0) && op_valid(iOp)) state_nxt = SHIFT;
          else                                  state_nxt = DONE;
        end
      end
      SHIFT: begin
        if (count == AMT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand latch and per-step shift.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state   <= IDLE;
      oResult <= '0;
      count   <= '0;
      op      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (iStart) begin
          oResult <= iData;
          op      <= iOp;
          count   <= iAmount;
        end
      end else if (state == SHIFT) begin
        oResult <= shift_step(oResult, op);
        count   <= count - AMT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb_alu_shift_sequencer
//   Self-checking bench for alu_shift_sequencer. Expected results come from a
//   whole-amount arithmetic model (shift/rotate by n in one expression) and an
//   expected latency derived from the amount and op validity.
module tb_alu_shift_sequencer;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic             iClock;
  logic             iReset;
  logic             iStart;
  logic [WIDTH-1:0] iData;
  logic [2:0]       iOp;
  logic [AMT_W-1:0] iAmount;
  logic [WIDTH-1:0] oResult;
  logic             oBusy;
  logic             oDone;

  int n_checks = 0;
  int n_errors = 0;

  alu_shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .iClock  (iClock),
    .iReset  (iReset),
    .iStart  (iStart),
    .iData   (iData),
    .iOp     (iOp),
    .iAmount (iAmount),
    .oResult (oResult),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_valid(input logic [2:0] op);
`ifdef ARITH_SHIFT_EN
    return op <= 3'd4;
`else
    return op <= 3'd3;
`endif
  endfunction

  // Final result of applying op by amt in one go.
  function automatic logic [WIDTH-1:0] model_result(input logic [WIDTH-1:0] d,
                                                    input logic [2:0] op,
                                                    input int amt);
    logic [2*WIDTH-1:0] dd;
    logic [2*WIDTH-1:0] t;
    logic signed [WIDTH-1:0] sd;
    int n;
    dd = {d, d};
    n  = amt % WIDTH;
    sd = d;
    if (!model_valid(op) || amt == 0) return d;
    case (op)
      3'd0: return (amt >= WIDTH) ? '0 : d >> amt;
      3'd1: return (amt >= WIDTH) ? '0 : d << amt;
      3'd2: begin t = dd >> n; return t[WIDTH-1:0]; end
      3'd3: begin t = dd << n; return t[2*WIDTH-1:WIDTH]; end
      default: return sd >>> amt;
    endcase
  endfunction

  // Issue one operation and check busy/done/result every cycle up to one
  // cycle past done. glitch_at > 0 re-pulses iStart (0xFFFF) in that cycle.
  task automatic run_op(input string name, input logic [WIDTH-1:0] d,
                        input logic [2:0] op, input int amt, input int glitch_at);
    int lat;
    logic [WIDTH-1:0] exp;
    exp = model_result(d, op, amt);
    lat = (model_valid(op) && amt != 0) ? amt + 1 : 1;
    @(negedge iClock);
    iStart  = 1'b1;
    iData   = d;
    iOp     = op;
    iAmount = AMT_W'(amt);
    @(negedge iClock);  // cycle +1 after acceptance
    for (int k = 1; k <= lat + 1; k++) begin
      if (k > 1) @(negedge iClock);
      iStart  = 1'b0;
      iData   = WIDTH'($urandom);
      iOp     = 3'($urandom);
      iAmount = AMT_W'($urandom);
      chk({name, " busy"}, {31'd0, oBusy}, {31'd0, k <= lat});
      chk({name, " done"}, {31'd0, oDone}, {31'd0, k == lat});
      if (k >= lat) chk({name, " result"}, {16'd0, oResult}, {16'd0, exp});
      if (k == glitch_at) begin
        iStart = 1'b1;
        iData  = 16'hFFFF;
        iOp    = 3'd0;
      end
    end
    @(negedge iClock);
    iStart = 1'b0;
  endtask

  initial begin
    iReset  = 1'b1;
    iStart  = 1'b0;
    iData   = '0;
    iOp     = '0;
    iAmount = '0;
    repeat (2) @(posedge iClock);
    @(negedge iClock);
    chk("reset result", {16'd0, oResult}, 32'h0);
    chk("reset busy", {31'd0, oBusy}, 32'h0);
    chk("reset done", {31'd0, oDone}, 32'h0);
    iReset = 1'b0;

    run_op("srl", 16'h8001, 3'd0, 4, 0);
    run_op("rol", 16'h8001, 3'd3, 1, 0);
    run_op("ror", 16'h0001, 3'd2, 4, 0);
    run_op("sll15", 16'hFFFF, 3'd1, 15, 0);
    run_op("amt0", 16'h1234, 3'd1, 0, 0);
    run_op("op7", 16'h1234, 3'd7, 5, 0);
    run_op("op4", 16'h8000, 3'd4, 3, 0);
    run_op("busy_ign", 16'h0001, 3'd1, 8, 3);
    run_op("done_ign", 16'h00F0, 3'd2, 2, 3);

    // Reset in the middle of an operation: back to idle, no done pulse.
    @(negedge iClock);
    iStart  = 1'b1;
    iData   = 16'h0001;
    iOp     = 3'd1;
    iAmount = 4'd8;
    @(negedge iClock);
    iStart = 1'b0;
    repeat (2) @(negedge iClock);
    iReset = 1'b1;
    @(negedge iClock);
    iReset = 1'b0;
    chk("mid_rst result", {16'd0, oResult}, 32'h0);
    chk("mid_rst busy", {31'd0, oBusy}, 32'h0);
    for (int k = 0; k < 10; k++) begin
      chk("mid_rst done", {31'd0, oDone}, 32'h0);
      @(negedge iClock);
    end

    for (int i = 0; i < 40; i++)
      run_op("rand", WIDTH'($urandom), 3'($urandom), int'($urandom_range(0, 15)), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
